servo_pwm_gen: RTL
==================

# servo_pwm_gen

Generates the physical servo PWM waveform from the PWM on-time produced by the servo direction-to-on-time stage. Sits directly downstream of that stage and drives the pen-lift servo pin. A fixed-frequency frame (default 20 ms at 50 MHz) is built from a clock prescaler and a frame counter. The requested on-time is sampled once per frame, so the pulse width never changes mid-pulse.

## Interface
Parameters:
- PWM_BITS, 16, width of on_time and of the frame counter
- PRESCALE, 50, clocks per PWM unit (1 µs at 50 MHz); ≥1
- PERIOD, 20000, PWM units per frame; must be ≤ 2^PWM_BITS − 1
- MIN_ON, 1000, lower clamp bound (used only with the clamp macro)
- MAX_ON, 2000, upper clamp bound (used only with the clamp macro)

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-low reset
- en  in  1  enables waveform generation
- on_time  in  PWM_BITS  requested high time in PWM units
- pwm_out  out  1  servo PWM pin, registered
- frame_start  out  1  one-cycle pulse at the first cycle of each frame
- active_on_time  out  PWM_BITS  on-time currently in effect (shadow register)

## Operation
- Prescaler: pre_cnt counts 0..PRESCALE−1. tick = (pre_cnt == PRESCALE−1).
- Frame counter: frm_cnt advances on tick and wraps from PERIOD−1 to 0.
- Shadow register: loaded from on_time (clamped when the macro is enabled) on the clock edge where frm_cnt wraps to 0. While en=0 it loads every cycle.
- pwm_out next value = en & (frm_cnt < shadow), registered.
- State: IDLE (en=0) and RUN (en=1).
  - IDLE: pre_cnt=0, frm_cnt=0, pwm_out=0, frame_start=0.
  - IDLE→RUN on en=1. frame_start pulses on the first RUN cycle. The frame begins with counters at 0, using the shadow value loaded on the previous cycle.
  - RUN→IDLE on en=0. Counters clear and pwm_out drops on the next edge; the current pulse is truncated.
- frame_start also pulses for one cycle each time frm_cnt wraps to 0 in RUN.
- Boundaries:
  - on_time=0: pwm_out constantly 0.
  - on_time ≥ PERIOD: pwm_out constantly 1 while en=1.
  - on_time changes mid-frame: no effect until the next frame.
  - on_time change coinciding with the wrap edge: the new value is captured.
- Compare is unsigned and PWM_BITS wide; no arithmetic overflow is possible.

## Timing
- Reset values: pwm_out=0, frame_start=0, active_on_time=0, all counters 0, state IDLE. Reset is asynchronous and takes effect immediately, including mid-pulse.
- Frame length is exactly PERIOD·PRESCALE clocks.
- High time is exactly min(shadow, PERIOD)·PRESCALE clocks.
- pwm_out lags the counter compare by one clock. The rising edge occurs one cycle after frame_start is asserted.
- en to first pwm_out rise: 2 clocks when shadow > 0.
- No backpressure; on_time is level-sampled.

## Configuration
- SERVO_PWM_CLAMP_EN defined: the shadow loads min(max(on_time, MIN_ON), MAX_ON).
- SERVO_PWM_CLAMP_EN undefined: the shadow loads on_time unmodified, and MIN_ON/MAX_ON are ignored.

## Structure
- Shared constants belong in the processor header with the existing servo macros:
  - servo PWM width
  - frame period
  - prescale
  - clamp bounds
- IDLE/RUN state typedef goes in Servo_PKG as ServoPwmState_t.
- One sub-module: servo_pwm_tick_gen (prescaler, with sync clear and tick output). The frame counter, shadow register and compare stay in the top module.

## Test plan
All cases use PRESCALE=2, PERIOD=10, PWM_BITS=8, clamp off unless stated.
- Reset: hold reset low with en=1 and on_time=3 → pwm_out=0, frame_start=0, active_on_time=0. Release reset → first frame_start 1 cycle later.
- Steady state: en=1, on_time=3 → pwm_out high for 6 clocks in every 20. frame_start pulses every 20 clocks, and pwm_out rises 1 clock after each pulse.
- Mid-frame update: change on_time 3→7 at clock 5 of a frame → current frame 6 clocks high, next frame 14 clocks high. active_on_time updates at the wrap.
- Extremes: on_time=0 → pwm_out always 0. on_time=12 → pwm_out always 1. With SERVO_PWM_CLAMP_EN, MIN_ON=1, MAX_ON=8: high time is 2 and 16 clocks respectively.
- Enable toggling: drop en at clock 3 of a high pulse → pwm_out=0 next clock and counters 0. Re-raise en → frame_start on the first RUN cycle and a full 6-clock pulse.
- Async reset mid-pulse: assert reset between clock edges while pwm_out=1 → pwm_out 0 before the next edge.

Source files
------------

// File: rtl/servo_pwm_gen_pkg.sv
// Shared servo PWM constants and the IDLE/RUN state type.
package servo_pwm_gen_pkg;

   localparam int unsigned ServoPwmBits     = 16;
   localparam int unsigned ServoPwmPeriod   = 20000;
   localparam int unsigned ServoPwmPrescale = 50;
   localparam int unsigned ServoPwmMinOn    = 1000;
   localparam int unsigned ServoPwmMaxOn    = 2000;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } ServoPwmState_t;

endpackage

// File: rtl/servo_pwm_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 and flags the last count as tick; clr holds it at 0.
module servo_pwm_tick_gen
   import servo_pwm_gen_pkg::*;
#(
   parameter int unsigned PRESCALE = ServoPwmPrescale
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CntW-1:0] PreMax = CntW'(PRESCALE - 1);

   logic [CntW-1:0] pre_cnt_q, pre_cnt_d;

   assign tick = (pre_cnt_q == PreMax);

   always_comb begin
      pre_cnt_d = pre_cnt_q;
      if (clr || tick) begin
         pre_cnt_d = '0;
      end else begin
         pre_cnt_d = pre_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: prescaled frame counter, per-frame shadowed on-time, registered output.
// Define SERVO_PWM_CLAMP_EN to clamp the sampled on-time into [MIN_ON, MAX_ON].
module servo_pwm_gen
   import servo_pwm_gen_pkg::*;
#(
   parameter int unsigned PWM_BITS = ServoPwmBits,
   parameter int unsigned PRESCALE = ServoPwmPrescale,
   parameter int unsigned PERIOD   = ServoPwmPeriod,
   parameter int unsigned MIN_ON   = ServoPwmMinOn,
   parameter int unsigned MAX_ON   = ServoPwmMaxOn
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [PWM_BITS-1:0] on_time,
   output logic                pwm_out,
   output logic                frame_start,
   output logic [PWM_BITS-1:0] active_on_time
);

   localparam logic [PWM_BITS-1:0] FrmMax = PWM_BITS'(PERIOD - 1);

   ServoPwmState_t      state_q, state_d;
   logic [PWM_BITS-1:0] frm_cnt_q, frm_cnt_d;
   logic [PWM_BITS-1:0] shadow_q, shadow_d;
   logic [PWM_BITS-1:0] load_val;
   logic                pwm_q, pwm_d;
   logic                fs_q, fs_d;
   logic                tick, running, wrap;

`ifdef SERVO_PWM_CLAMP_EN
   localparam logic [PWM_BITS-1:0] MinOn = PWM_BITS'(MIN_ON);
   localparam logic [PWM_BITS-1:0] MaxOn = PWM_BITS'(MAX_ON);

   always_comb begin
      load_val = on_time;
      if (on_time < MinOn) begin
         load_val = MinOn;
      end else if (on_time > MaxOn) begin
         load_val = MaxOn;
      end
   end
`else
   assign load_val = on_time;
`endif

   assign running = (state_q == StRun) && en;
   assign wrap    = running && tick && (frm_cnt_q == FrmMax);

   servo_pwm_tick_gen #(
      .PRESCALE(PRESCALE)
   ) u_tick_gen (
      .clk  (clk),
      .reset(reset),
      .clr  (!running),
      .tick (tick)
   );

   always_comb begin
      state_d   = state_q;
      frm_cnt_d = frm_cnt_q;
      shadow_d  = shadow_q;
      pwm_d     = 1'b0;
      fs_d      = 1'b0;

      case (state_q)
         StIdle: if (en) state_d = StRun;
         StRun:  if (!en) state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (!running) begin
         frm_cnt_d = '0;
      end else if (tick) begin
         frm_cnt_d = wrap ? '0 : frm_cnt_q + 1'b1;
      end

      // Shadow tracks on_time continuously while idle, so a fresh start uses the latest request.
      if ((state_q == StIdle) || !en || wrap) begin
         shadow_d = load_val;
      end

      pwm_d = running && (frm_cnt_q < shadow_q);
      fs_d  = en && ((state_q == StIdle) || wrap);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         frm_cnt_q <= '0;
         shadow_q  <= '0;
         pwm_q     <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         frm_cnt_q <= frm_cnt_d;
         shadow_q  <= shadow_d;
         pwm_q     <= pwm_d;
         fs_q      <= fs_d;
      end
   end

   assign pwm_out        = pwm_q;
   assign frame_start    = fs_q;
   assign active_on_time = shadow_q;

endmodule
